// File: rtl/saes_sbox_arbiter.sv
// Shares one S-AES 4-bit S-box between the round state (ST_NIBS nibbles) and key schedule (KEY_NIBS nibbles).
// Latency: N cycles from the accept edge to done (N = nibble count); one request per N+1 cycles.
// Backpressure: ready is offered only in IDLE to the arbitration winner; SAES_SBOX_ARB_FIXED_PRIO_EN makes key win ties.

// S-AES nibble substitution table.
// Latency: combinational.
// Backpressure: none.
module sbox (
    input  logic [3:0] data,
    output logic [3:0] dout
);
    always_comb begin
        case (data)
            4'h0: dout = 4'h9;
            4'h1: dout = 4'h4;
            4'h2: dout = 4'hA;
            4'h3: dout = 4'hB;
            4'h4: dout = 4'hD;
            4'h5: dout = 4'h1;
            4'h6: dout = 4'h8;
            4'h7: dout = 4'h5;
            4'h8: dout = 4'h6;
            4'h9: dout = 4'h2;
            4'hA: dout = 4'h0;
            4'hB: dout = 4'h3;
            4'hC: dout = 4'hC;
            4'hD: dout = 4'hE;
            4'hE: dout = 4'hF;
            4'hF: dout = 4'h7;
            default: dout = 4'h0;
        endcase
    end
endmodule

module saes_sbox_arbiter #(
    parameter int ST_NIBS  = 4,
    parameter int KEY_NIBS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  st_valid,
    output logic                  st_ready,
    input  logic [4*ST_NIBS-1:0]  st_data,
    output logic                  st_done,
    output logic [4*ST_NIBS-1:0]  st_dout,
    input  logic                  key_valid,
    output logic                  key_ready,
    input  logic [4*KEY_NIBS-1:0] key_data,
    output logic                  key_done,
    output logic [4*KEY_NIBS-1:0] key_dout,
    output logic                  busy
);
    localparam int SW   = 4 * ST_NIBS;
    localparam int KW   = 4 * KEY_NIBS;
    localparam int MAXN = (ST_NIBS > KEY_NIBS) ? ST_NIBS : KEY_NIBS;
    localparam int WW   = 4 * MAXN;
    localparam int CW   = $clog2(MAXN + 1);

    typedef enum logic {IDLE, SUB} state_t;

    state_t        state, state_nxt;
    logic [WW-1:0] work, shadow, shadow_nxt;
    logic          owner_st;
    logic [CW-1:0] cnt, nlast;
    logic          prio_st, win_st, accept, last;
    logic [3:0]    sb_in, sb_out;

`ifdef SAES_SBOX_ARB_FIXED_PRIO_EN
    assign prio_st = 1'b0;
`else
    logic ptr_st;
    assign prio_st = ptr_st;

    // Pointer names the port that wins the next tie; it hands priority to the loser.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ptr_st <= 1'b0;
        else if (accept)
            ptr_st <= !win_st;
    end
`endif

    sbox u_sbox (.data(sb_in), .dout(sb_out));

    always_comb begin
        state_nxt = state;
        st_ready  = 1'b0;
        key_ready = 1'b0;
        win_st    = 1'b0;
        sb_in     = 4'h0;
        last      = 1'b0;
        case (state)
            IDLE: begin
                if (!rst) begin
                    win_st    = st_valid && (!key_valid || prio_st);
                    st_ready  = win_st;
                    key_ready = key_valid && !win_st;
                    if (st_valid || key_valid)
                        state_nxt = SUB;
                end
            end
            SUB: begin
                sb_in = work[WW-1 -: 4];
                last  = (cnt == nlast);
                if (last)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign accept     = st_ready || key_ready;
    assign busy       = (state == SUB);
    // Words are left-aligned in work so the MSB nibble is always at the top; results shift in at the bottom.
    assign shadow_nxt = {shadow[WW-5:0], sb_out};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            work     <= '0;
            shadow   <= '0;
            owner_st <= 1'b0;
            cnt      <= '0;
            nlast    <= '0;
            st_dout  <= '0;
            key_dout <= '0;
            st_done  <= 1'b0;
            key_done <= 1'b0;
        end else begin
            state    <= state_nxt;
            st_done  <= 1'b0;
            key_done <= 1'b0;
            if (accept) begin
                owner_st <= win_st;
                cnt      <= '0;
                shadow   <= '0;
                if (win_st) begin
                    nlast <= CW'(ST_NIBS - 1);
                    work  <= WW'(st_data) << (WW - SW);
                end else begin
                    nlast <= CW'(KEY_NIBS - 1);
                    work  <= WW'(key_data) << (WW - KW);
                end
            end else if (state == SUB) begin
                work   <= work << 4;
                shadow <= shadow_nxt;
                cnt    <= cnt + 1'b1;
                if (last) begin
                    if (owner_st) begin
                        st_dout <= shadow_nxt[SW-1:0];
                        st_done <= 1'b1;
                    end else begin
                        key_dout <= shadow_nxt[KW-1:0];
                        key_done <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_saes_sbox_arbiter.sv
// Scoreboard bench for saes_sbox_arbiter: stimulus pushes expected words and done cycles, a negedge monitor checks them.
module tb_saes_sbox_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        st_valid = 1'b0, key_valid = 1'b0;
    logic [15:0] st_data = '0;
    logic [7:0]  key_data = '0;
    logic        st_ready, key_ready, st_done, key_done, busy;
    logic [15:0] st_dout;
    logic [7:0]  key_dout;

`ifdef SAES_SBOX_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    typedef struct {
        logic [15:0] dat;
        int          cyc;
    } exp_t;

    exp_t        sq[$];
    exp_t        kq[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    logic [15:0] cur_st = '0;
    logic [7:0]  cur_key = '0;

    saes_sbox_arbiter dut (
        .clk(clk), .rst(rst),
        .st_valid(st_valid), .st_ready(st_ready), .st_data(st_data),
        .st_done(st_done), .st_dout(st_dout),
        .key_valid(key_valid), .key_ready(key_ready), .key_data(key_data),
        .key_done(key_done), .key_dout(key_dout),
        .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: pops expectations on done pulses and verifies held outputs in between.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            sq.delete();
            kq.delete();
            cur_st  = '0;
            cur_key = '0;
            chk("rst_st_dout", 32'(st_dout), 32'(cur_st));
            chk("rst_key_dout", 32'(key_dout), 32'(cur_key));
            chk("rst_busy_done", {29'd0, busy, st_done, key_done}, 32'd0);
            chk("rst_ready", {30'd0, st_ready, key_ready}, 32'd0);
        end else begin
            if (st_done) begin
                if (sq.size() == 0) begin
                    chk("st_done_unexpected", 32'(st_done), 32'd0);
                end else begin
                    e = sq.pop_front();
                    chk("st_dout", 32'(st_dout), 32'(e.dat));
                    chk("st_latency_cycle", 32'(cyc), 32'(e.cyc));
                    cur_st = e.dat;
                end
            end else begin
                chk("st_dout_hold", 32'(st_dout), 32'(cur_st));
            end
            if (key_done) begin
                if (kq.size() == 0) begin
                    chk("key_done_unexpected", 32'(key_done), 32'd0);
                end else begin
                    e = kq.pop_front();
                    chk("key_dout", 32'(key_dout), 32'(e.dat[7:0]));
                    chk("key_latency_cycle", 32'(cyc), 32'(e.cyc));
                    cur_key = e.dat[7:0];
                end
            end else begin
                chk("key_dout_hold", 32'(key_dout), 32'(cur_key));
            end
            if (busy)
                chk("ready_while_busy", {30'd0, st_ready, key_ready}, 32'd0);
        end
    end

    task automatic wait_ready(input bit want_st, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (want_st ? st_ready : key_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok)
            chk(want_st ? "st_ready_timeout" : "key_ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        rst = 1'b1; st_valid = 1'b0; key_valid = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic req_st(input logic [15:0] d, input logic [15:0] x);
        bit ok;
        @(posedge clk); #1;
        st_valid = 1'b1; st_data = d;
        wait_ready(1'b1, ok);
        if (ok) begin
            chk("st_only_winner", 32'(key_ready), 32'd0);
            @(posedge clk); #1;
            sq.push_back('{dat: x, cyc: cyc + 4});
        end
        st_valid = 1'b0; st_data = '0;
    endtask

    task automatic req_key(input logic [7:0] d, input logic [7:0] x);
        bit ok;
        @(posedge clk); #1;
        key_valid = 1'b1; key_data = d;
        wait_ready(1'b0, ok);
        if (ok) begin
            @(posedge clk); #1;
            kq.push_back('{dat: {8'h00, x}, cyc: cyc + 2});
        end
        key_valid = 1'b0; key_data = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int a, acc0, acc1, acc2;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Single requests on each port; other port's dout must hold.
        req_st(16'h1234, 16'h4ABD);
        req_key(8'hA5, 8'h01);
        repeat (6) @(posedge clk);

        // Simultaneous requests from reset, then a second tie while the key is being served.
        pulse_reset();
        st_valid = 1'b1; st_data = 16'hFFFF; key_valid = 1'b1; key_data = 8'h00;
        @(negedge clk);
        chk("tie1_ready", {30'd0, st_ready, key_ready}, 32'b01);
        @(posedge clk); #1;
        a = cyc;
        kq.push_back('{dat: 16'h0099, cyc: a + 2});
        key_data = 8'h12;
        wait_ready(!FIXED, ok);
        if (ok) begin
            chk("tie2_cycle", 32'(cyc), 32'(a + 2));
            chk("tie2_ready", {30'd0, st_ready, key_ready}, FIXED ? 32'b01 : 32'b10);
            @(posedge clk); #1;
            if (FIXED) begin
                kq.push_back('{dat: 16'h004A, cyc: cyc + 2});
                key_valid = 1'b0;
            end else begin
                sq.push_back('{dat: 16'h7777, cyc: cyc + 4});
                st_valid = 1'b0;
            end
        end
        wait_ready(FIXED, ok);
        if (ok) begin
            @(posedge clk); #1;
            if (FIXED) begin
                sq.push_back('{dat: 16'h7777, cyc: cyc + 4});
                st_valid = 1'b0;
            end else begin
                kq.push_back('{dat: 16'h004A, cyc: cyc + 2});
                key_valid = 1'b0;
            end
        end
        st_valid = 1'b0; key_valid = 1'b0;
        repeat (8) @(posedge clk);

        // Reset mid-operation aborts without a done pulse.
        #1 st_valid = 1'b1; st_data = 16'h0C9E;
        wait_ready(1'b1, ok);
        @(posedge clk); #1;
        st_valid = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (6) @(posedge clk);
        req_st(16'h0C9E, 16'h9C2F);
        repeat (6) @(posedge clk);

        // Back-to-back with valid held: acceptances every 5 cycles.
        #1 st_valid = 1'b1; st_data = 16'h1234;
        wait_ready(1'b1, ok);
        @(posedge clk); #1;
        acc0 = cyc; sq.push_back('{dat: 16'h4ABD, cyc: cyc + 4}); st_data = 16'h0C9E;
        wait_ready(1'b1, ok);
        @(posedge clk); #1;
        acc1 = cyc; sq.push_back('{dat: 16'h9C2F, cyc: cyc + 4}); st_data = 16'hFFFF;
        wait_ready(1'b1, ok);
        @(posedge clk); #1;
        acc2 = cyc; sq.push_back('{dat: 16'h7777, cyc: cyc + 4});
        st_valid = 1'b0;
        chk("b2b_gap1", 32'(acc1 - acc0), 32'd5);
        chk("b2b_gap2", 32'(acc2 - acc1), 32'd5);

        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("st_queue_drained", 32'(sq.size()), 32'd0);
        chk("key_queue_drained", 32'(kq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
